// File: rtl/rr_port_scheduler.sv
// rr_port_scheduler: round-robin, packet-locked, credit-gated output port scheduler.
// Optional idle-hold timeout is built when RR_HOLD_TIMEOUT_EN is defined.
module rr_port_scheduler #(
    parameter int NREQ     = 10,
    parameter int CREDITS  = 4,
    parameter int HOLD_MAX = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] last,
    input  logic            credit_ret,
    output logic [NREQ-1:0] gnt,
    output logic [3:0]      sel,
    output logic            xfer,
    output logic [3:0]      credit_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Refuse to elaborate outside the supported parameter ranges.
    if (NREQ < 2 || NREQ > 16 || CREDITS < 1 || CREDITS > 15 || HOLD_MAX < 1) begin : g_bad_param
        $error("rr_port_scheduler: parameter out of range");
    end

    state_t          state_q;
    logic [3:0]      ptr_q;
    logic [NREQ-1:0] gnt_q;
    logic [3:0]      sel_q;
    logic [3:0]      credit_q;
    logic [3:0]      credit_d;

    logic            pick_found;
    logic [3:0]      pick_idx;
    logic [NREQ-1:0] pick_onehot;
    logic            owner_req;
    logic            owner_last;
    logic            xfer_w;
    logic            release_w;
    logic            timeout;
    logic [3:0]      ptr_next;

    // Wrap-around search for the first requester starting at ptr.
    always_comb begin
        int idx;
        idx         = 0;
        pick_found  = 1'b0;
        pick_idx    = '0;
        pick_onehot = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!pick_found && req[idx]) begin
                pick_found = 1'b1;
                pick_idx   = 4'(idx);
            end
        end
        pick_onehot[pick_idx] = 1'b1;
    end

    // Owner-side view: does the granted input still request, is its head a tail.
    always_comb begin
        owner_req  = 1'b0;
        owner_last = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_q[i]) begin
                owner_req  = req[i];
                owner_last = last[i];
            end
        end
    end

    assign xfer_w = !rst && (state_q == BUSY) && owner_req && (credit_q != 4'd0);

    assign release_w = (xfer_w && owner_last) || !owner_req || timeout;

    assign ptr_next = (sel_q == 4'(NREQ - 1)) ? 4'd0 : sel_q + 4'd1;

`ifdef RR_HOLD_TIMEOUT_EN
    localparam int HW = $clog2(HOLD_MAX) + 1;

    logic [HW-1:0] hold_q;

    // Stall-cycle counter; the owner is evicted after HOLD_MAX cycles without a flit.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q <= '0;
        end else if (state_q == IDLE || xfer_w) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_q + 1'b1;
        end
    end

    assign timeout = (state_q == BUSY) && !xfer_w && (hold_q == HW'(HOLD_MAX - 1));
`else
    assign timeout = 1'b0;
`endif

    // Arbitration FSM: grant is registered and locked until tail, abandon or timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            sel_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (pick_found) begin
                        gnt_q   <= pick_onehot;
                        sel_q   <= pick_idx;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (release_w) begin
                        gnt_q   <= '0;
                        ptr_q   <= ptr_next;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Credit arithmetic: a simultaneous spend and return cancel; returns saturate.
    always_comb begin
        credit_d = credit_q;
        if (xfer_w && !credit_ret) begin
            credit_d = credit_q - 4'd1;
        end else if (credit_ret && !xfer_w && credit_q != 4'(CREDITS)) begin
            credit_d = credit_q + 4'd1;
        end
    end

    // Downstream credit counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            credit_q <= 4'(CREDITS);
        end else begin
            credit_q <= credit_d;
        end
    end

    assign gnt        = gnt_q;
    assign sel        = sel_q;
    assign xfer       = xfer_w;
    assign credit_cnt = credit_q;

    // Structural invariants of the grant bundle.
    a_gnt_onehot0 : assert property (@(posedge clk) $onehot0(gnt_q));
    a_xfer_owner  : assert property (@(posedge clk) xfer_w |-> (gnt_q != '0));
    a_sel_match   : assert property (@(posedge clk)
        (gnt_q != '0) |-> gnt_q[sel_q]);
    a_credit_cap  : assert property (@(posedge clk) credit_q <= 4'(CREDITS));

endmodule

// File: tb/tb_rr_port_scheduler.sv
// tb_rr_port_scheduler: scoreboard bench for rr_port_scheduler against a
// behavioural model of the arbitration, packet-lock and credit rules.
module tb_rr_port_scheduler;

    localparam int NREQ     = 10;
    localparam int CREDITS  = 4;
    localparam int HOLD_MAX = 8;

    typedef struct {
        int gnt;
        int sel;
        int xfer;
        int cred;
    } exp_t;

    logic            clk;
    logic            rst;
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] last;
    logic            credit_ret;
    logic [NREQ-1:0] gnt;
    logic [3:0]      sel;
    logic            xfer;
    logic [3:0]      credit_cnt;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cycles_pushed = 0;
    int   cycles_popped = 0;

    int m_owner = -1;
    int m_ptr   = 0;
    int m_sel   = 0;
    int m_cred  = CREDITS;
    int m_hold  = 0;

    rr_port_scheduler #(
        .NREQ    (NREQ),
        .CREDITS (CREDITS),
        .HOLD_MAX(HOLD_MAX)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .last      (last),
        .credit_ret(credit_ret),
        .gnt       (gnt),
        .sel       (sel),
        .xfer      (xfer),
        .credit_cnt(credit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     name, act, exp, cycles_popped);
        end
    endtask

    // Drive one cycle of inputs, predict what the DUT shows this cycle,
    // then advance the model across the coming rising edge.
    task automatic cycle(input logic [NREQ-1:0] r, input logic [NREQ-1:0] l,
                         input logic cr, input logic rs);
        exp_t e;
        bit   x;
        bit   rel;
        req        = r;
        last       = l;
        credit_ret = cr;
        rst        = rs;
        x = (rs == 1'b0) && (m_owner >= 0) && r[m_owner] && (m_cred > 0);
        e.gnt  = (m_owner < 0) ? 0 : (1 << m_owner);
        e.sel  = m_sel;
        e.xfer = x ? 1 : 0;
        e.cred = m_cred;
        sb.push_back(e);
        cycles_pushed++;
        if (rs) begin
            m_owner = -1;
            m_ptr   = 0;
            m_sel   = 0;
            m_cred  = CREDITS;
            m_hold  = 0;
        end else begin
            if (m_owner < 0) begin
                for (int k = 0; k < NREQ; k++) begin
                    if (m_owner < 0 && r[(m_ptr + k) % NREQ]) begin
                        m_owner = (m_ptr + k) % NREQ;
                    end
                end
                if (m_owner >= 0) begin
                    m_sel  = m_owner;
                    m_hold = 0;
                end
            end else begin
                rel = (x && l[m_owner]) || !r[m_owner];
`ifdef RR_HOLD_TIMEOUT_EN
                if (x) begin
                    m_hold = 0;
                end else begin
                    m_hold++;
                    if (m_hold == HOLD_MAX) rel = 1'b1;
                end
`endif
                if (rel) begin
                    m_ptr   = (m_owner + 1) % NREQ;
                    m_owner = -1;
                    m_hold  = 0;
                end
            end
            if (x && !cr) m_cred--;
            else if (cr && !x && m_cred < CREDITS) m_cred++;
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: every cycle the DUT presents its outputs, compare with the queue head.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("gnt",        int'(gnt),        e.gnt);
            chk("sel",        int'(sel),        e.sel);
            chk("xfer",       int'(xfer),       e.xfer);
            chk("credit_cnt", int'(credit_cnt), e.cred);
            cycles_popped++;
        end
    end

    localparam logic [NREQ-1:0] ALL  = '1;
    localparam logic [NREQ-1:0] NONE = '0;

    initial begin
        logic [NREQ-1:0] r;
        logic [NREQ-1:0] l;
        logic [NREQ-1:0] b4;
        logic [NREQ-1:0] b1;
        logic [NREQ-1:0] b0;
        b4 = NONE;
        b4[4] = 1'b1;
        b1 = NONE;
        b1[1] = 1'b1;
        b0 = NONE;
        b0[0] = 1'b1;
        req = '0;
        last = '0;
        credit_ret = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        cycle(NONE, NONE, 1'b0, 1'b1);
        cycle(NONE, NONE, 1'b0, 1'b1);

        // Two single-flit packets from inputs 0 and 2.
        r = 10'b0000000101;
        for (int i = 0; i < 4; i++) cycle(r, ALL, 1'b0, 1'b0);
        cycle(NONE, ALL, 1'b0, 1'b0);
        cycle(NONE, ALL, 1'b1, 1'b0);
        cycle(NONE, ALL, 1'b1, 1'b0);

        // Wrap-around: input 9 then inputs 9|3 -> 3 wins.
        r = 10'b1000000000;
        for (int i = 0; i < 3; i++) cycle(r, ALL, 1'b1, 1'b0);
        r = 10'b1000001000;
        for (int i = 0; i < 3; i++) cycle(r, ALL, 1'b1, 1'b0);
        cycle(NONE, NONE, 1'b0, 1'b0);

        // Packet lock: 3-flit packet on input 4 while input 1 waits.
        cycle(b4 | b1, NONE, 1'b0, 1'b0);
        cycle(b4 | b1, NONE, 1'b1, 1'b0);
        cycle(b4 | b1, NONE, 1'b1, 1'b0);
        cycle(b4 | b1, b4, 1'b1, 1'b0);
        cycle(b1, ALL, 1'b0, 1'b0);
        cycle(b1, ALL, 1'b0, 1'b0);
        cycle(NONE, NONE, 1'b0, 1'b0);

        // Credit stall: long packet with no returns, then single returns.
        for (int i = 0; i < 8; i++) cycle(b4, NONE, 1'b0, 1'b0);
        cycle(b4, NONE, 1'b1, 1'b0);
        cycle(b4, NONE, 1'b0, 1'b0);
        cycle(b4, NONE, 1'b1, 1'b0);
        cycle(b4, NONE, 1'b1, 1'b0);
        // Owner stalled at zero credits with another requester waiting.
        for (int i = 0; i < 6; i++) cycle(b4, NONE, 1'b0, 1'b0);
        for (int i = 0; i < 22; i++) cycle(b4 | b1, NONE, 1'b0, 1'b0);
        cycle(NONE, NONE, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) cycle(NONE, NONE, 1'b1, 1'b0);

        // Mid-packet reset, then input 0 must win from ptr=0.
        cycle(b4 | b0, NONE, 1'b0, 1'b0);
        cycle(b4 | b0, NONE, 1'b0, 1'b0);
        cycle(b4 | b0, NONE, 1'b0, 1'b1);
        cycle(b4 | b0, ALL, 1'b0, 1'b0);
        cycle(b4 | b0, ALL, 1'b0, 1'b0);
        cycle(NONE, NONE, 1'b0, 1'b0);

        // Randomised traffic.
        for (int i = 0; i < 600; i++) begin
            r = NONE;
            l = NONE;
            for (int j = 0; j < NREQ; j++) begin
                r[j] = ($urandom_range(0, 99) < 35);
                l[j] = ($urandom_range(0, 99) < 30);
            end
            cycle(r, l, ($urandom_range(0, 99) < 40), ($urandom_range(0, 99) < 2));
        end

        cycle(NONE, NONE, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0 || cycles_popped != cycles_pushed) begin
            errors++;
            $display("FAIL drain: popped %0d of %0d cycles", cycles_popped, cycles_pushed);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
